// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the register-bus transfer arbiter.
// Used by rr_picker and bus_transfer_arbiter.
package bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WRITE = 2'd2
    } state_e;

    localparam int unsigned MAX_REG = 64;

    // Select width for an n-entry index; never narrower than one bit.
    function automatic int unsigned sel_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // One-hot strobe for idx; all-zero when idx is outside the n populated entries.
    function automatic logic [MAX_REG-1:0] onehot(input int unsigned idx, input int unsigned n);
        logic [MAX_REG-1:0] v;
        v = '0;
        if (idx < n) begin
            v = MAX_REG'(1) << idx;
        end
        return v;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first requester at or after ptr, cyclically.
module rr_picker
    import bus_arb_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDX_W = sel_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N_REQ-1:0] win_c_o,
    output logic [IDX_W-1:0] idx_c_o
);

    logic             found;
    logic [IDX_W-1:0] pos;

    always_comb begin
        win_c_o = '0;
        idx_c_o = '0;
        found   = 1'b0;
        pos     = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            pos = IDX_W'((32'(ptr_i) + k) % N_REQ);
            if (!found && req_i[pos]) begin
                win_c_o[pos] = 1'b1;
                idx_c_o      = pos;
                found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_transfer_arbiter.sv
// Round-robin sequencer for register-to-register moves on the shared bus (IDLE -> LOAD -> WRITE).
// Optional bus locking is compiled in with `define BUS_ARB_LOCK_EN.
module bus_transfer_arbiter
    import bus_arb_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned N_REG = 8,
    parameter int unsigned SEL_W = sel_w(N_REG)
) (
    input  logic                   clk,
    input  logic                   RST_N,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*SEL_W-1:0] src_sel,
    input  logic [N_REQ*SEL_W-1:0] dst_sel,
    input  logic [N_REQ-1:0]       lock,
    output logic [N_REQ-1:0]       grant,
    output logic [N_REQ-1:0]       ack,
    output logic [N_REG-1:0]       LDBUS,
    output logic [N_REG-1:0]       WR,
    output logic                   busy
);

    localparam int unsigned PTR_W = sel_w(N_REQ);
    localparam logic [PTR_W-1:0] LAST_REQ = PTR_W'(N_REQ - 1);

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   owner_q, owner_d;
    logic [SEL_W-1:0]   src_q, src_d;
    logic [SEL_W-1:0]   dst_q, dst_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [N_REQ-1:0]   ack_q, ack_d;
    logic [N_REG-1:0]   ldbus_q, ldbus_d;
    logic [N_REG-1:0]   wr_q, wr_d;
    logic               busy_q, busy_d;

    logic [SEL_W-1:0]   src_arr [N_REQ];
    logic [SEL_W-1:0]   dst_arr [N_REQ];
    logic [N_REQ-1:0]   pick_req;
    logic [PTR_W-1:0]   pick_ptr;
    logic [N_REQ-1:0]   pick_win;
    logic [PTR_W-1:0]   pick_idx;
    logic [PTR_W-1:0]   owner_inc;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_split
        assign src_arr[gi] = src_sel[gi*SEL_W +: SEL_W];
        assign dst_arr[gi] = dst_sel[gi*SEL_W +: SEL_W];
    end

    assign owner_inc = (owner_q == LAST_REQ) ? '0 : owner_q + PTR_W'(1);

`ifdef BUS_ARB_LOCK_EN
    logic hold_q, hold_d;

    // While held, only the holder may win; releasing restarts rotation after the holder.
    always_comb begin
        pick_req = req;
        pick_ptr = ptr_q;
        if (hold_q) begin
            if (lock[owner_q]) begin
                pick_req = req & (N_REQ'(1) << owner_q);
            end else begin
                pick_ptr = owner_inc;
            end
        end
    end
`else
    logic unused_lock;

    assign unused_lock = ^lock;
    assign pick_req    = req;
    assign pick_ptr    = ptr_q;
`endif

    rr_picker #(
        .N_REQ (N_REQ),
        .IDX_W (PTR_W)
    ) u_picker (
        .req_i   (pick_req),
        .ptr_i   (pick_ptr),
        .win_c_o (pick_win),
        .idx_c_o (pick_idx)
    );

    // Next state and next registered outputs, decoded from the state being entered.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        src_d   = src_q;
        dst_d   = dst_q;
        grant_d = '0;
        ack_d   = '0;
        ldbus_d = '0;
        wr_d    = '0;
        busy_d  = 1'b0;
`ifdef BUS_ARB_LOCK_EN
        hold_d  = hold_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef BUS_ARB_LOCK_EN
                if (hold_q && !lock[owner_q]) begin
                    hold_d = 1'b0;
                    ptr_d  = owner_inc;
                end
`endif
                if (|pick_req) begin
                    state_d = LOAD;
                    owner_d = pick_idx;
                    src_d   = src_arr[pick_idx];
                    dst_d   = dst_arr[pick_idx];
                    grant_d = pick_win;
                    ldbus_d = N_REG'(onehot(32'(src_arr[pick_idx]), N_REG));
                    busy_d  = 1'b1;
                end
            end
            LOAD: begin
                state_d = WRITE;
                grant_d = grant_q;
                ack_d   = grant_q;
                ldbus_d = N_REG'(onehot(32'(src_q), N_REG));
                wr_d    = N_REG'(onehot(32'(dst_q), N_REG));
                busy_d  = 1'b1;
            end
            WRITE: begin
                state_d = IDLE;
`ifdef BUS_ARB_LOCK_EN
                if (lock[owner_q]) begin
                    hold_d = 1'b1;
                end else begin
                    hold_d = 1'b0;
                    ptr_d  = owner_inc;
                end
`else
                ptr_d = owner_inc;
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            grant_q <= '0;
            ack_q   <= '0;
            ldbus_q <= '0;
            wr_q    <= '0;
            busy_q  <= 1'b0;
`ifdef BUS_ARB_LOCK_EN
            hold_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            grant_q <= grant_d;
            ack_q   <= ack_d;
            ldbus_q <= ldbus_d;
            wr_q    <= wr_d;
            busy_q  <= busy_d;
`ifdef BUS_ARB_LOCK_EN
            hold_q  <= hold_d;
`endif
        end
    end

    assign grant = grant_q;
    assign ack   = ack_q;
    assign LDBUS = ldbus_q;
    assign WR    = wr_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_bus_transfer_arbiter.sv
// Randomized and directed bench for bus_transfer_arbiter against a transaction-level model.
// Two instances share stimulus: 8 registers and 6 registers (out-of-range index masking).
module tb_bus_transfer_arbiter;

    localparam int NQ = 4;
    localparam int SW = 3;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [3:0]  lock;
    logic [11:0] src_sel;
    logic [11:0] dst_sel;

    logic [3:0]  grant8, ack8, grant6, ack6;
    logic [7:0]  ld8, wr8;
    logic [5:0]  ld6, wr6;
    logic        busy8, busy6;

    bus_transfer_arbiter #(.N_REQ(4), .N_REG(8)) u_dut8 (
        .clk(clk), .RST_N(rst_n), .req(req), .src_sel(src_sel), .dst_sel(dst_sel),
        .lock(lock), .grant(grant8), .ack(ack8), .LDBUS(ld8), .WR(wr8), .busy(busy8)
    );

    bus_transfer_arbiter #(.N_REQ(4), .N_REG(6)) u_dut6 (
        .clk(clk), .RST_N(rst_n), .req(req), .src_sel(src_sel), .dst_sel(dst_sel),
        .lock(lock), .grant(grant6), .ack(ack6), .LDBUS(ld6), .WR(wr6), .busy(busy6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Transaction-level model: phase 0 idle, 1 source on bus, 2 write + ack.
    int m_phase, m_owner, m_src, m_dst, m_ptr, m_hold;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int field(input logic [11:0] bus, input int c);
        return int'((bus >> (c * SW)) & 12'h7);
    endfunction

    function automatic int strobe(input int idx, input int nreg);
        return (idx < nreg) ? (1 << idx) : 0;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_owner = 0; m_src = 0; m_dst = 0; m_ptr = 0; m_hold = 0;
    endtask

    task automatic model_edge();
        int start;
        logic [3:0] cand;
        case (m_phase)
            0: begin
                cand  = req;
                start = m_ptr;
`ifdef BUS_ARB_LOCK_EN
                if (m_hold != 0) begin
                    if (lock[m_owner]) begin
                        cand = req & (4'b0001 << m_owner);
                    end else begin
                        m_hold = 0;
                        m_ptr  = (m_owner + 1) % NQ;
                        start  = m_ptr;
                    end
                end
`endif
                for (int k = 0; k < NQ; k++) begin
                    int c;
                    c = (start + k) % NQ;
                    if (cand[c]) begin
                        m_owner = c;
                        m_src   = field(src_sel, c);
                        m_dst   = field(dst_sel, c);
                        m_phase = 1;
                        break;
                    end
                end
            end
            1: m_phase = 2;
            default: begin
`ifdef BUS_ARB_LOCK_EN
                if (lock[m_owner]) m_hold = 1;
                else begin
                    m_hold = 0;
                    m_ptr  = (m_owner + 1) % NQ;
                end
`else
                m_ptr = (m_owner + 1) % NQ;
`endif
                m_phase = 0;
            end
        endcase
    endtask

    task automatic check_outputs();
        int eg, ea;
        eg = (m_phase != 0) ? (1 << m_owner) : 0;
        ea = (m_phase == 2) ? (1 << m_owner) : 0;
        check_eq("grant8", 32'(grant8), 32'(eg));
        check_eq("ack8",   32'(ack8),   32'(ea));
        check_eq("busy8",  32'(busy8),  32'(m_phase != 0));
        check_eq("ldbus8", 32'(ld8),    32'((m_phase != 0) ? strobe(m_src, 8) : 0));
        check_eq("wr8",    32'(wr8),    32'((m_phase == 2) ? strobe(m_dst, 8) : 0));
        check_eq("grant6", 32'(grant6), 32'(eg));
        check_eq("ack6",   32'(ack6),   32'(ea));
        check_eq("busy6",  32'(busy6),  32'(m_phase != 0));
        check_eq("ldbus6", 32'(ld6),    32'((m_phase != 0) ? strobe(m_src, 6) : 0));
        check_eq("wr6",    32'(wr6),    32'((m_phase == 2) ? strobe(m_dst, 6) : 0));
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic set_core(input int c, input int s, input int d);
        src_sel[c*SW +: SW] = SW'(s);
        dst_sel[c*SW +: SW] = SW'(d);
    endtask

    initial begin
        int order [5];
        int n;
        order = '{0, 1, 2, 3, 0};

        rst_n = 1'b0; req = '0; lock = '0; src_sel = '0; dst_sel = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        rst_n = 1'b1;

        // Single transfer: core 1 moves r2 -> r5.
        set_core(1, 2, 5);
        req = 4'b0010;
        step();
        check_eq("t2_load_ldbus", 32'(ld8), 32'h04);
        check_eq("t2_load_wr",    32'(wr8), 32'h00);
        step();
        check_eq("t2_wr_ldbus", 32'(ld8),  32'h04);
        check_eq("t2_wr_wr",    32'(wr8),  32'h20);
        check_eq("t2_wr_ack",   32'(ack8), 32'h2);
        req = 4'b0000;
        step();
        check_eq("t2_idle_busy", 32'(busy8), 32'h0);

        // Asynchronous reset in the middle of LOAD.
        set_core(0, 3, 3);
        req = 4'b0001;
        step();
        check_eq("rst_pre_busy", 32'(busy8), 32'h1);
        rst_n = 1'b0;
        #1;
        check_eq("rst_grant", 32'(grant8), 32'h0);
        check_eq("rst_ldbus", 32'(ld8),    32'h0);
        check_eq("rst_busy",  32'(busy8),  32'h0);
        model_reset();
        req = 4'b0000;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();

        // Fairness with all cores requesting continuously, starting from ptr=0.
        for (int c = 0; c < NQ; c++) set_core(c, c + 1, 7 - c);
        req = 4'b1111;
        n = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (m_phase == 1 && n < 5) begin
                check_eq("fair_grant", 32'(grant8), 32'(1 << order[n]));
                n++;
            end
        end
        check_eq("fair_count", 32'(n), 32'd5);
        req = 4'b0000;
        repeat (3) step();

        // Self-reload on r7, which lies outside the 6-register instance.
        set_core(2, 7, 7);
        req = 4'b0100;
        step();
        step();
        check_eq("b_ldbus8", 32'(ld8),  32'h80);
        check_eq("b_wr8",    32'(wr8),  32'h80);
        check_eq("b_wr6",    32'(wr6),  32'h00);
        check_eq("b_ack6",   32'(ack6), 32'h4);
        req = 4'b0000;
        step();

        // Owner changes its request after grant; latched transfer must complete.
        set_core(3, 1, 6);
        req = 4'b1000;
        step();
        set_core(3, 4, 0);
        req = 4'b0000;
        step();
        check_eq("mc_ldbus", 32'(ld8),  32'h02);
        check_eq("mc_wr",    32'(wr8),  32'h40);
        check_eq("mc_ack",   32'(ack8), 32'h8);
        step();

        // Random traffic obeying the request/ack handshake.
        for (int cyc = 0; cyc < 500; cyc++) begin
            for (int c = 0; c < NQ; c++) begin
                if (m_phase == 2 && m_owner == c) begin
                    if ($urandom_range(0, 1) == 0) req[c] = 1'b0;
                    else begin
                        set_core(c, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
                        req[c] = 1'b1;
                    end
                end else if (m_phase == 1 && m_owner == c) begin
                    if ($urandom_range(0, 3) == 0) begin
                        set_core(c, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
                        req[c] = 1'($urandom_range(0, 1));
                    end
                end else if (!req[c] && $urandom_range(0, 3) == 0) begin
                    set_core(c, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
                    req[c] = 1'b1;
                end
            end
            lock = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
